// File: rtl/fc_layer_sequencer.sv
// Purpose : address/tag sequencer for one fully connected layer; streams every (neuron, input) pair, then writes one result per neuron.
// Latency : rd_en from the start edge; mac_en = rd_en + RD_LAT; out_we = mac_last + MAC_LAT; done the cycle after the final out_we.
// Backpressure: hold=1 freezes operand issue (bubble, rd_en=0) while the tag pipeline keeps draining; hold is ignored outside RUN.
// Ports:
//   clk, reset (async, active-low), start, hold         : control inputs
//   busy, done                                          : pass status
//   rd_en, addr_in, addr_w                              : SRAM read issue
//   mac_en, mac_first, mac_last                         : operand-aligned MAC tags
//   out_we, out_addr                                    : accumulator result write
module fc_layer_sequencer #(
  parameter int N_IN    = 784,
  parameter int N_OUT   = 300,
  parameter int AW_IN   = 10,
  parameter int AW_W    = 18,
  parameter int AW_OUT  = 9,
  parameter int W_BASE  = 0,
  parameter int RD_LAT  = 1,
  parameter int MAC_LAT = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              hold,
  output logic              busy,
  output logic              done,
  output logic              rd_en,
  output logic [AW_IN-1:0]  addr_in,
  output logic [AW_W-1:0]   addr_w,
  output logic              mac_en,
  output logic              mac_first,
  output logic              mac_last,
  output logic              out_we,
  output logic [AW_OUT-1:0] out_addr
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;

  // Tag carried with each issued operand pair; all fields are 0 for a bubble.
  typedef struct packed {
    logic              vld;
    logic              first;
    logic              last;
    logic [AW_OUT-1:0] n;
  } tag_t;

  typedef struct packed {
    logic              vld;
    logic [AW_OUT-1:0] n;
  } wr_t;

  localparam logic [AW_IN-1:0]  I_LAST  = AW_IN'(N_IN - 1);
  localparam logic [AW_OUT-1:0] N_LAST  = AW_OUT'(N_OUT - 1);
  localparam logic [AW_W-1:0]   W_FIRST = AW_W'(W_BASE);

  state_t            state;
  // Counters hold the NEXT pair to issue; cnt_w is an offset from W_BASE so
  // every counter sits at 0 while idle and the first issue needs no special case.
  logic [AW_IN-1:0]  cnt_i;
  logic [AW_OUT-1:0] cnt_n;
  logic [AW_W-1:0]   cnt_w;

  tag_t              iss;                 // tag aligned with rd_en
  tag_t              rd_pipe [RD_LAT];    // SRAM read latency
  wr_t               wr_pipe [MAC_LAT];   // MAC result latency
  tag_t              mac_tag;
  wr_t               wr_in;

  logic              issue_go;
  logic              last_pair;
  logic              pass_end;

  assign issue_go  = ((state == IDLE) && start) || ((state == RUN) && !hold);
  assign last_pair = (cnt_i == I_LAST) && (cnt_n == N_LAST);
  assign mac_tag   = rd_pipe[RD_LAT-1];

  always_comb begin
    wr_in = '0;
    if (mac_tag.vld && mac_tag.last) begin
      wr_in.vld = 1'b1;
      wr_in.n   = mac_tag.n;
    end
  end

  // Only neuron N_OUT-1 produces a write with that index, so its write marks the end of the pass.
  assign pass_end = (state == DRAIN) && wr_pipe[MAC_LAT-1].vld &&
                    (wr_pipe[MAC_LAT-1].n == N_LAST);

  assign rd_en     = iss.vld;
  assign mac_en    = mac_tag.vld;
  assign mac_first = mac_tag.first;
  assign mac_last  = mac_tag.last;
  assign out_we    = wr_pipe[MAC_LAT-1].vld;
  assign out_addr  = wr_pipe[MAC_LAT-1].n;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      addr_in <= '0;
      addr_w  <= '0;
      cnt_i   <= '0;
      cnt_n   <= '0;
      cnt_w   <= '0;
      iss     <= '0;
      for (int k = 0; k < RD_LAT; k++)  rd_pipe[k] <= '0;
      for (int k = 0; k < MAC_LAT; k++) wr_pipe[k] <= '0;
    end else begin
      done    <= 1'b0;
      iss     <= '0;
      addr_in <= '0;
      addr_w  <= '0;

      if (issue_go) begin
        iss.vld   <= 1'b1;
        iss.first <= (cnt_i == '0);
        iss.last  <= (cnt_i == I_LAST);
        iss.n     <= cnt_n;
        addr_in   <= cnt_i;
        addr_w    <= W_FIRST + cnt_w;
        if (last_pair) begin
          // Clear now so the counters are already 0 when the pass returns to IDLE.
          cnt_i <= '0;
          cnt_n <= '0;
          cnt_w <= '0;
        end else if (cnt_i == I_LAST) begin
          cnt_i <= '0;
          cnt_n <= cnt_n + AW_OUT'(1);
          cnt_w <= cnt_w + AW_W'(1);
        end else begin
          cnt_i <= cnt_i + AW_IN'(1);
          cnt_w <= cnt_w + AW_W'(1);
        end
      end

      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
          end
        end
        RUN: begin
          if (!hold && last_pair) state <= DRAIN;
        end
        DRAIN: begin
          if (pass_end) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase

      rd_pipe[0] <= iss;
      for (int k = 1; k < RD_LAT; k++)  rd_pipe[k] <= rd_pipe[k-1];
      wr_pipe[0] <= wr_in;
      for (int k = 1; k < MAC_LAT; k++) wr_pipe[k] <= wr_pipe[k-1];
    end
  end

endmodule

// File: tb/tb_fc_layer_sequencer.sv
// Bench for fc_layer_sequencer: three instances (4x3 nominal, 4x3 with long
// latencies and W_BASE=100, 300x10 second-layer size). Traces are recorded one
// entry per cycle (cycle 1 = the cycle after the start edge) and compared with
// a schedule built from the pass description plus hand-computed spot values.
module tb_fc_layer_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;
  logic a_start, a_hold, b_start, b_hold, c_start, c_hold;

  logic a_busy, a_done, a_rd_en, a_mac_en, a_mac_first, a_mac_last, a_out_we;
  logic [9:0] a_addr_in; logic [17:0] a_addr_w; logic [8:0] a_out_addr;
  logic b_busy, b_done, b_rd_en, b_mac_en, b_mac_first, b_mac_last, b_out_we;
  logic [9:0] b_addr_in; logic [17:0] b_addr_w; logic [8:0] b_out_addr;
  logic c_busy, c_done, c_rd_en, c_mac_en, c_mac_first, c_mac_last, c_out_we;
  logic [9:0] c_addr_in; logic [17:0] c_addr_w; logic [8:0] c_out_addr;

  fc_layer_sequencer #(.N_IN(4), .N_OUT(3), .W_BASE(0), .RD_LAT(1), .MAC_LAT(1)) u_a (
    .clk(clk), .reset(rst_n), .start(a_start), .hold(a_hold),
    .busy(a_busy), .done(a_done), .rd_en(a_rd_en), .addr_in(a_addr_in), .addr_w(a_addr_w),
    .mac_en(a_mac_en), .mac_first(a_mac_first), .mac_last(a_mac_last),
    .out_we(a_out_we), .out_addr(a_out_addr));

  fc_layer_sequencer #(.N_IN(4), .N_OUT(3), .W_BASE(100), .RD_LAT(3), .MAC_LAT(2)) u_b (
    .clk(clk), .reset(rst_n), .start(b_start), .hold(b_hold),
    .busy(b_busy), .done(b_done), .rd_en(b_rd_en), .addr_in(b_addr_in), .addr_w(b_addr_w),
    .mac_en(b_mac_en), .mac_first(b_mac_first), .mac_last(b_mac_last),
    .out_we(b_out_we), .out_addr(b_out_addr));

  fc_layer_sequencer #(.N_IN(300), .N_OUT(10), .W_BASE(0), .RD_LAT(1), .MAC_LAT(1)) u_c (
    .clk(clk), .reset(rst_n), .start(c_start), .hold(c_hold),
    .busy(c_busy), .done(c_done), .rd_en(c_rd_en), .addr_in(c_addr_in), .addr_w(c_addr_w),
    .mac_en(c_mac_en), .mac_first(c_mac_first), .mac_last(c_mac_last),
    .out_we(c_out_we), .out_addr(c_out_addr));

  typedef struct {
    integer bs, dn, rd, ai, aw, me, mf, ml, we, oa;
  } cyc_t;

  cyc_t obs   [64];
  cyc_t exp_c [64];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic logic [63:0] pk(input cyc_t s);
    pk = {s.bs[0], s.dn[0], s.rd[0], s.me[0], s.mf[0], s.ml[0], s.we[0],
          s.oa[8:0], s.ai[11:0], s.aw[19:0], 16'd0};
  endfunction

  task automatic sample(input int dut, output cyc_t s);
    s = '{default: 0};
    case (dut)
      0: s = '{a_busy, a_done, a_rd_en, a_addr_in, a_addr_w, a_mac_en, a_mac_first, a_mac_last, a_out_we, a_out_addr};
      1: s = '{b_busy, b_done, b_rd_en, b_addr_in, b_addr_w, b_mac_en, b_mac_first, b_mac_last, b_out_we, b_out_addr};
      default: s = '{c_busy, c_done, c_rd_en, c_addr_in, c_addr_w, c_mac_en, c_mac_first, c_mac_last, c_out_we, c_out_addr};
    endcase
  endtask

  task automatic drive(input int dut, input logic st, input logic hd);
    case (dut)
      0: begin a_start = st; a_hold = hd; end
      1: begin b_start = st; b_hold = hd; end
      default: begin c_start = st; c_hold = hd; end
    endcase
  endtask

  // Pulse start, then record ncyc cycles. hold is high during cycles
  // hold_lo..hold_hi; start is re-raised during cycles st1 and st2.
  task automatic capture(input int dut, input int ncyc, input int hold_lo, input int hold_hi,
                         input int st1, input int st2);
    @(negedge clk);
    drive(dut, 1'b1, 1'b0);
    for (int c = 1; c <= ncyc; c++) begin
      @(negedge clk);
      sample(dut, obs[c]);
      drive(dut, (c == st1) || (c == st2), (c >= hold_lo) && (c <= hold_hi));
    end
    drive(dut, 1'b0, 1'b0);
  endtask

  task automatic clear_exp();
    for (int c = 0; c < 64; c++) exp_c[c] = '{default: 0};
  endtask

  // Expected schedule of one pass: pair p goes out on the first cycle whose
  // preceding cycle had hold low (the start cycle always issues).
  task automatic add_pass(input int start_cyc, input int nin, input int nout, input int rd,
                          input int mac, input int wb, input int hold_lo, input int hold_hi);
    int c = start_cyc;
    int p = 0;
    int lastwe = 0;
    while (p < nin * nout && c < 64) begin
      if (c == start_cyc || !((c - 1 >= hold_lo) && (c - 1 <= hold_hi))) begin
        exp_c[c].rd = 1; exp_c[c].ai = p % nin; exp_c[c].aw = wb + p;
        if (c + rd < 64) begin
          exp_c[c+rd].me = 1;
          exp_c[c+rd].mf = (p % nin == 0) ? 1 : 0;
          exp_c[c+rd].ml = (p % nin == nin - 1) ? 1 : 0;
        end
        if (p % nin == nin - 1) begin
          lastwe = c + rd + mac;
          if (lastwe < 64) begin exp_c[lastwe].we = 1; exp_c[lastwe].oa = p / nin; end
        end
        p++;
      end
      c++;
    end
    for (int k = start_cyc; k <= lastwe && k < 64; k++) exp_c[k].bs = 1;
    if (lastwe + 1 < 64) exp_c[lastwe+1].dn = 1;
  endtask

  task automatic test_reset();
    cyc_t s;
    rst_n = 1'b0;
    drive(0, 0, 0); drive(1, 0, 0); drive(2, 0, 0);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      sample(d, s);
      n_cmp++;
      if (pk(s) !== 64'd0) begin
        n_bad++;
        $display("FAIL reset_outputs dut%0d: got %h want 0", d, pk(s));
      end
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_nominal();
    int nrd = 0;
    clear_exp();
    add_pass(1, 4, 3, 1, 1, 0, 0, -1);
    capture(0, 20, 0, -1, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      n_cmp++;
      if (pk(obs[c]) !== pk(exp_c[c])) begin
        n_bad++;
        $display("FAIL nominal_trace cyc %0d: got %h want %h", c, pk(obs[c]), pk(exp_c[c]));
      end
      if (obs[c].rd == 1) nrd++;
    end
    for (int k = 0; k < 3; k++) begin
      n_cmp++;
      if (obs[6+4*k].we !== 1 || obs[6+4*k].oa !== k) begin
        n_bad++;
        $display("FAIL nominal_out_we cyc %0d: got we=%0d addr=%0d want we=1 addr=%0d",
                 6 + 4 * k, obs[6+4*k].we, obs[6+4*k].oa, k);
      end
    end
    n_cmp++;
    if (obs[15].dn !== 1 || obs[15].bs !== 0 || obs[14].bs !== 1) begin
      n_bad++;
      $display("FAIL nominal_done: got done15=%0d busy15=%0d busy14=%0d want 1 0 1",
               obs[15].dn, obs[15].bs, obs[14].bs);
    end
    n_cmp++;
    if (nrd !== 12 || obs[12].aw !== 11 || obs[12].ai !== 3) begin
      n_bad++;
      $display("FAIL nominal_issue: got count=%0d aw12=%0d ai12=%0d want 12 11 3", nrd, obs[12].aw, obs[12].ai);
    end
  endtask

  task automatic test_hold();
    clear_exp();
    add_pass(1, 4, 3, 1, 1, 0, 6, 7);
    capture(0, 24, 6, 7, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      n_cmp++;
      if (pk(obs[c]) !== pk(exp_c[c])) begin
        n_bad++;
        $display("FAIL hold_trace cyc %0d: got %h want %h", c, pk(obs[c]), pk(exp_c[c]));
      end
    end
    n_cmp++;
    if (obs[7].rd !== 0 || obs[8].rd !== 0 || obs[9].rd !== 1 || obs[9].ai !== 2 || obs[9].aw !== 6) begin
      n_bad++;
      $display("FAIL hold_issue: got rd7=%0d rd8=%0d rd9=%0d ai9=%0d aw9=%0d want 0 0 1 2 6",
               obs[7].rd, obs[8].rd, obs[9].rd, obs[9].ai, obs[9].aw);
    end
    n_cmp++;
    if (obs[8].me !== 0 || obs[9].me !== 0 || obs[10].me !== 1) begin
      n_bad++;
      $display("FAIL hold_mac_gap: got me8=%0d me9=%0d me10=%0d want 0 0 1", obs[8].me, obs[9].me, obs[10].me);
    end
    n_cmp++;
    if (obs[17].dn !== 1 || obs[16].we !== 1 || obs[16].oa !== 2) begin
      n_bad++;
      $display("FAIL hold_done: got done17=%0d we16=%0d oa16=%0d want 1 1 2", obs[17].dn, obs[16].we, obs[16].oa);
    end
  endtask

  task automatic test_back_to_back();
    clear_exp();
    add_pass(1, 4, 3, 1, 1, 0, 0, -1);
    add_pass(16, 4, 3, 1, 1, 0, 0, -1);
    capture(0, 34, 0, -1, 5, 15);
    for (int c = 1; c <= 34; c++) begin
      n_cmp++;
      if (pk(obs[c]) !== pk(exp_c[c])) begin
        n_bad++;
        $display("FAIL b2b_trace cyc %0d: got %h want %h", c, pk(obs[c]), pk(exp_c[c]));
      end
    end
    n_cmp++;
    if (obs[16].rd !== 1 || obs[16].bs !== 1 || obs[16].aw !== 0 || obs[30].dn !== 1) begin
      n_bad++;
      $display("FAIL b2b_restart: got rd16=%0d busy16=%0d aw16=%0d done30=%0d want 1 1 0 1",
               obs[16].rd, obs[16].bs, obs[16].aw, obs[30].dn);
    end
  endtask

  task automatic test_latency();
    int nbs = 0;
    clear_exp();
    add_pass(1, 4, 3, 3, 2, 100, 0, -1);
    capture(1, 24, 0, -1, 0, 0);
    for (int c = 1; c <= 24; c++) begin
      n_cmp++;
      if (pk(obs[c]) !== pk(exp_c[c])) begin
        n_bad++;
        $display("FAIL latency_trace cyc %0d: got %h want %h", c, pk(obs[c]), pk(exp_c[c]));
      end
      if (obs[c].bs == 1) nbs++;
    end
    n_cmp++;
    if (nbs !== 17 || obs[18].dn !== 1) begin
      n_bad++;
      $display("FAIL latency_busy: got busy_cycles=%0d done18=%0d want 17 1", nbs, obs[18].dn);
    end
    n_cmp++;
    if (obs[1].aw !== 100 || obs[12].aw !== 111 || obs[3].me !== 0 || obs[4].me !== 1 || obs[4].mf !== 1) begin
      n_bad++;
      $display("FAIL latency_addr: got aw1=%0d aw12=%0d me3=%0d me4=%0d mf4=%0d want 100 111 0 1 1",
               obs[1].aw, obs[12].aw, obs[3].me, obs[4].me, obs[4].mf);
    end
    n_cmp++;
    if (obs[7].ml !== 1 || obs[8].we !== 0 || obs[9].we !== 1 || obs[9].oa !== 0) begin
      n_bad++;
      $display("FAIL latency_out_we: got ml7=%0d we8=%0d we9=%0d oa9=%0d want 1 0 1 0",
               obs[7].ml, obs[8].we, obs[9].we, obs[9].oa);
    end
  endtask

  task automatic test_reset_mid();
    cyc_t s;
    int stray = 0;
    @(negedge clk);
    drive(0, 1'b1, 1'b0);
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      drive(0, 1'b0, 1'b0);
    end
    sample(0, s);
    n_cmp++;
    if (s.rd !== 1 || s.ai !== 1 || s.aw !== 9) begin
      n_bad++;
      $display("FAIL rstmid_point: got rd=%0d ai=%0d aw=%0d want 1 1 9", s.rd, s.ai, s.aw);
    end
    #1 rst_n = 1'b0;
    #1 sample(0, s);
    n_cmp++;
    if (pk(s) !== 64'd0) begin
      n_bad++;
      $display("FAIL rstmid_async: got %h want 0", pk(s));
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      sample(0, s);
      if (pk(s) !== 64'd0) stray++;
    end
    n_cmp++;
    if (stray !== 0) begin
      n_bad++;
      $display("FAIL rstmid_quiet: got %0d active cycles want 0", stray);
    end
    clear_exp();
    add_pass(1, 4, 3, 1, 1, 0, 0, -1);
    capture(0, 20, 0, -1, 0, 0);
    for (int c = 1; c <= 20; c++) begin
      n_cmp++;
      if (pk(obs[c]) !== pk(exp_c[c])) begin
        n_bad++;
        $display("FAIL rstmid_fresh cyc %0d: got %h want %h", c, pk(obs[c]), pk(exp_c[c]));
      end
    end
  endtask

  task automatic test_layer2();
    cyc_t s;
    int nbs = 0, nwe = 0, last_aw = -1, max_oa = -1;
    bit got_done = 1'b0;
    @(negedge clk);
    drive(2, 1'b1, 1'b0);
    for (int c = 1; c <= 5000 && !got_done; c++) begin
      @(negedge clk);
      drive(2, 1'b0, 1'b0);
      sample(2, s);
      if (s.bs == 1) nbs++;
      if (s.rd == 1) last_aw = s.aw;
      if (s.we == 1) begin nwe++; if (s.oa > max_oa) max_oa = s.oa; end
      if (s.dn == 1) got_done = 1'b1;
    end
    n_cmp++;
    if (!got_done) begin
      n_bad++;
      $display("FAIL layer2_timeout: got no done within 5000 cycles want done");
    end
    n_cmp++;
    if (last_aw !== 2999 || max_oa !== 9) begin
      n_bad++;
      $display("FAIL layer2_addr: got last_aw=%0d max_oa=%0d want 2999 9", last_aw, max_oa);
    end
    n_cmp++;
    if (nwe !== 10 || nbs !== 3002) begin
      n_bad++;
      $display("FAIL layer2_count: got out_we=%0d busy=%0d want 10 3002", nwe, nbs);
    end
    @(negedge clk);
    sample(2, s);
    n_cmp++;
    if (s.dn !== 0 || s.bs !== 0) begin
      n_bad++;
      $display("FAIL layer2_pulse: got done=%0d busy=%0d after done want 0 0", s.dn, s.bs);
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_hold();
    test_back_to_back();
    test_latency();
    test_reset_mid();
    test_layer2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
